// File: rtl/imuldiv_muldiv_issue_unit.sv
// imuldiv_muldiv_issue_unit: request stage + in-order tag FIFO front end for the iterative mul/div unit; define IMULDIV_ISSUE_STATS_EN for stat_issued/stat_done/stat_err outputs
module imuldiv_muldiv_issue_unit #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_val,
  output logic             cmd_rdy,
  input  logic [2:0]       cmd_fn,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  input  logic             cmd_sel_hi,
  output logic [2:0]       muldivreq_msg_fn,
  output logic [31:0]      muldivreq_msg_a,
  output logic [31:0]      muldivreq_msg_b,
  output logic             muldivreq_val,
  input  logic             muldivreq_rdy,
  input  logic [63:0]      muldivresp_msg_result,
  input  logic             muldivresp_val,
  output logic             muldivresp_rdy,
  output logic             wb_val,
  input  logic             wb_rdy,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_data
`ifdef IMULDIV_ISSUE_STATS_EN
  ,
  output logic [31:0]      stat_issued,
  output logic [31:0]      stat_done,
  output logic             stat_err
`endif
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic             req_val;
  logic [2:0]       req_fn;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic             hi_q  [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             nonempty;
  logic             cmd_fire;
  logic             req_fire;
  logic             resp_fire;
  // handshakes and the zero-latency response-to-writeback path
  always_comb begin
    nonempty         = count != '0;
    cmd_rdy          = (!req_val || muldivreq_rdy) && (count < FULL);
    cmd_fire         = cmd_val && cmd_rdy;
    req_fire         = req_val && muldivreq_rdy;
    muldivreq_val    = req_val;
    muldivreq_msg_fn = req_fn;
    muldivreq_msg_a  = req_a;
    muldivreq_msg_b  = req_b;
    wb_val           = muldivresp_val && nonempty;
    muldivresp_rdy   = wb_rdy && nonempty;
    resp_fire        = muldivresp_val && muldivresp_rdy;
    wb_tag           = tag_q[rd_ptr];
    wb_data          = hi_q[rd_ptr] ? muldivresp_msg_result[63:32] : muldivresp_msg_result[31:0];
  end
  // request stage: holds msg until the unit takes it, refilled by a same-cycle command
  always_ff @(posedge clk) begin
    if (reset) begin
      req_val <= 1'b0;
      req_fn  <= '0;
      req_a   <= '0;
      req_b   <= '0;
    end else if (cmd_fire) begin
      req_val <= 1'b1;
      req_fn  <= cmd_fn;
      req_a   <= cmd_a;
      req_b   <= cmd_b;
    end else if (req_fire) begin
      req_val <= 1'b0;
    end
  end
  // tag FIFO pointers and occupancy; push on command, pop on consumed response
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (cmd_fire) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (resp_fire) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(cmd_fire) - CW'(resp_fire);
    end
  end
  // tag FIFO storage; contents are don't-care while their slot is empty
  always_ff @(posedge clk) begin
    if (cmd_fire) begin
      tag_q[wr_ptr] <= cmd_tag;
      hi_q[wr_ptr]  <= cmd_sel_hi;
    end
  end
`ifdef IMULDIV_ISSUE_STATS_EN
  // issue/completion counters and sticky flag for responses with nothing outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued <= '0;
      stat_done   <= '0;
      stat_err    <= 1'b0;
    end else begin
      if (req_fire) stat_issued <= stat_issued + 32'd1;
      if (resp_fire) stat_done <= stat_done + 32'd1;
      if (muldivresp_val && !nonempty) stat_err <= 1'b1;
    end
  end
`endif
endmodule
